// File: rtl/teclado_pkg.sv
// Shared definitions for the ATM keypad: key codes, entry modes, debounce states.
// Latency: none (declarations only).
// Backpressure: none; the keypad path has no flow control.
package teclado_pkg;

  localparam logic [3:0] TECLA_ENTER  = 4'd10;
  localparam logic [3:0] TECLA_BORRAR = 4'd11;
  // Codes at or above this value are not assigned to any key.
  localparam logic [3:0] TECLA_INVALIDA_MIN = 4'd12;

  localparam logic MODO_PIN   = 1'b0;
  localparam logic MODO_MONTO = 1'b1;

  typedef enum logic [1:0] {
    IDLE,
    DEB_PRESS,
    HELD,
    DEB_RELEASE
  } deb_state_t;

  function automatic logic es_digito(input logic [3:0] tecla);
    return tecla < 4'd10;
  endfunction

endpackage

// File: rtl/teclado_atm_if.sv
// Keypad bundle: raw key inputs and the registered PIN/amount results.
// Latency: none (wiring only).
// Backpressure: none; results are strobes that the consumer must take when they fire.
interface teclado_atm_if;

  logic [3:0]  TECLA;
  logic        TECLA_VALIDA;
  logic        MODO;
  logic [3:0]  DIGITO;
  logic        DIGITO_STB;
  logic [31:0] MONTO;
  logic        MONTO_STB;
  logic [3:0]  CUENTA_DIG;
  logic        ERROR_TECLA;

  // Keypad / stimulus side.
  modport master (
    output TECLA, TECLA_VALIDA, MODO,
    input  DIGITO, DIGITO_STB, MONTO, MONTO_STB, CUENTA_DIG, ERROR_TECLA
  );

  // Decoder side.
  modport slave (
    input  TECLA, TECLA_VALIDA, MODO,
    output DIGITO, DIGITO_STB, MONTO, MONTO_STB, CUENTA_DIG, ERROR_TECLA
  );

endinterface

// File: rtl/teclado_atm_antirrebote.sv
// Key debouncer: accepts a key after DEB_CYCLES equal samples, re-arms after DEB_CYCLES low samples.
// Latency: acepta rises in the cycle whose closing edge takes the DEB_CYCLES-th stable sample.
// Backpressure: none; a held key yields a single acceptance (no auto-repeat).
module antirrebote
  import teclado_pkg::*;
#(
  parameter int DEB_CYCLES = 4
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [3:0] TECLA,
  input  logic       TECLA_VALIDA,
  output logic       acepta,
  output logic [3:0] codigo
);

  localparam int CW = (DEB_CYCLES < 2) ? 1 : $clog2(DEB_CYCLES + 1);
  localparam logic [CW-1:0] CNT_ULT = CW'(DEB_CYCLES - 1);

  deb_state_t    state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [3:0]    codigo_n;

  // State, stable-sample counter and latched key code.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state  <= IDLE;
      cnt    <= '0;
      codigo <= '0;
    end else begin
      state  <= state_n;
      cnt    <= cnt_n;
      codigo <= codigo_n;
    end
  end

  // Next state; acepta is combinational so the decoder can register its result on the accepting edge.
  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    codigo_n = codigo;
    acepta   = 1'b0;
    unique case (state)
      IDLE: begin
        if (TECLA_VALIDA) begin
          codigo_n = TECLA;
          cnt_n    = CW'(1);
          if (DEB_CYCLES <= 1) begin
            acepta  = 1'b1;
            cnt_n   = '0;
            state_n = HELD;
          end else begin
            state_n = DEB_PRESS;
          end
        end
      end
      DEB_PRESS: begin
        // A drop or a code change aborts; the new code is only counted from IDLE.
        if (!TECLA_VALIDA || TECLA != codigo) begin
          cnt_n   = '0;
          state_n = IDLE;
        end else if (cnt == CNT_ULT) begin
          acepta  = 1'b1;
          cnt_n   = '0;
          state_n = HELD;
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
      HELD: begin
        if (!TECLA_VALIDA) begin
          cnt_n   = CW'(1);
          state_n = (DEB_CYCLES <= 1) ? IDLE : DEB_RELEASE;
          if (DEB_CYCLES <= 1) cnt_n = '0;
        end
      end
      DEB_RELEASE: begin
        if (TECLA_VALIDA) begin
          cnt_n   = '0;
          state_n = HELD;
        end else if (cnt == CNT_ULT) begin
          cnt_n   = '0;
          state_n = IDLE;
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
      default: begin
        cnt_n   = '0;
        state_n = IDLE;
      end
    endcase
  end

endmodule

// File: rtl/teclado_atm.sv
// ATM keypad decoder: debounced keys become PIN digit strobes or a committed decimal amount.
// Latency: all outputs registered on the edge taking the DEB_CYCLES-th stable sample.
// Backpressure: none; strobes last one cycle and MONTO holds until the next commit.
module teclado_atm
  import teclado_pkg::*;
#(
  parameter int DEB_CYCLES = 4,
  parameter int MAX_DIG    = 9   // at most 9 so the 32-bit accumulator cannot overflow
) (
  input  logic          clock,
  input  logic          reset,
  teclado_atm_if.slave  bus
);

  logic        acepta;
  logic [3:0]  codigo;

  logic        modo_prev, modo_prev_n;
  logic [31:0] acc, acc_n, acc_base;
  logic [3:0]  cnt_dig, cnt_dig_n, cnt_base;
  logic [3:0]  digito, digito_n;
  logic        digito_stb, digito_stb_n;
  logic [31:0] monto, monto_n;
  logic        monto_stb, monto_stb_n;
  logic        error_tecla, error_tecla_n;

  antirrebote #(.DEB_CYCLES(DEB_CYCLES)) u_antirrebote (
    .clock        (clock),
    .reset        (reset),
    .TECLA        (bus.TECLA),
    .TECLA_VALIDA (bus.TECLA_VALIDA),
    .acepta       (acepta),
    .codigo       (codigo)
  );

  // Decode the accepted key against the mode sampled at acceptance.
  always_comb begin
    modo_prev_n   = modo_prev;
    acc_base      = acc;
    cnt_base      = cnt_dig;
    acc_n         = acc;
    cnt_dig_n     = cnt_dig;
    digito_n      = digito;
    digito_stb_n  = 1'b0;
    monto_n       = monto;
    monto_stb_n   = 1'b0;
    error_tecla_n = 1'b0;
    if (acepta) begin
      // A mode switch discards any half-typed amount before the key is applied.
      if (bus.MODO != modo_prev) begin
        acc_base = '0;
        cnt_base = '0;
      end
      modo_prev_n = bus.MODO;
      acc_n       = acc_base;
      cnt_dig_n   = cnt_base;
      if (codigo >= TECLA_INVALIDA_MIN) begin
        error_tecla_n = 1'b1;
      end else if (bus.MODO == MODO_PIN) begin
        if (es_digito(codigo)) begin
          digito_n     = codigo;
          digito_stb_n = 1'b1;
        end
      end else if (es_digito(codigo)) begin
        if (cnt_base < 4'(MAX_DIG)) begin
          acc_n     = acc_base * 32'd10 + 32'(codigo);
          cnt_dig_n = cnt_base + 4'd1;
        end else begin
          error_tecla_n = 1'b1;
        end
      end else if (codigo == TECLA_ENTER) begin
        if (cnt_base != 4'd0) begin
          monto_n     = acc_base;
          monto_stb_n = 1'b1;
          acc_n       = '0;
          cnt_dig_n   = '0;
        end else begin
          error_tecla_n = 1'b1;
        end
      end else begin
        acc_n     = '0;
        cnt_dig_n = '0;
      end
    end
  end

  // Register decoder state and every output.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      modo_prev   <= MODO_PIN;
      acc         <= '0;
      cnt_dig     <= '0;
      digito      <= '0;
      digito_stb  <= 1'b0;
      monto       <= '0;
      monto_stb   <= 1'b0;
      error_tecla <= 1'b0;
    end else begin
      modo_prev   <= modo_prev_n;
      acc         <= acc_n;
      cnt_dig     <= cnt_dig_n;
      digito      <= digito_n;
      digito_stb  <= digito_stb_n;
      monto       <= monto_n;
      monto_stb   <= monto_stb_n;
      error_tecla <= error_tecla_n;
    end
  end

  assign bus.DIGITO      = digito;
  assign bus.DIGITO_STB  = digito_stb;
  assign bus.MONTO       = monto;
  assign bus.MONTO_STB   = monto_stb;
  assign bus.CUENTA_DIG  = cnt_dig;
  assign bus.ERROR_TECLA = error_tecla;

endmodule

// File: doc/teclado_atm.md
TECLADO_ATM -- requirements
Module: teclado_atm

Interface
REQ-001 Parameters (name, default, meaning):
- DEB_CYCLES, 4: consecutive stable samples required to accept a press or a release.
- MAX_DIG, 9: maximum digits held in the amount buffer.

REQ-002 Ports (name, direction, width, meaning):
- clock, in, 1: single clock; all state changes on its rising edge.
- reset, in, 1: asynchronous, active-low reset.
- TECLA, in, 4: raw key code. 0-9 are digits, 10 is ENTER, 11 is BORRAR, 12-15 are invalid.
- TECLA_VALIDA, in, 1: level, high while a key is physically held.
- MODO, in, 1: 0 is PIN entry, 1 is amount entry.
- DIGITO, out, 4: accepted digit, valid while DIGITO_STB is high.
- DIGITO_STB, out, 1: one-cycle strobe per accepted PIN digit.
- MONTO, out, 32: last committed binary amount, held until the next commit.
- MONTO_STB, out, 1: one-cycle strobe when MONTO is committed.
- CUENTA_DIG, out, 4: digits currently held in the amount buffer.
- ERROR_TECLA, out, 1: one-cycle strobe on a rejected key.

Function
REQ-003 The debounce FSM SHALL have states IDLE, DEB_PRESS, HELD and DEB_RELEASE.
REQ-004 IDLE to DEB_PRESS: when TECLA_VALIDA=1 is sampled. The stable count starts at 1 and TECLA is latched.
REQ-005 In DEB_PRESS, TECLA_VALIDA=0 or TECLA differing from the latched code SHALL return the FSM to IDLE with no output.
REQ-006 Acceptance SHALL occur at the edge taking the DEB_CYCLES-th consecutive stable sample, and the FSM moves to HELD.
- The resulting strobe is high for exactly the following cycle.
- Latency from the first high sample to the strobe is DEB_CYCLES cycles.
REQ-007 HELD to DEB_RELEASE: on TECLA_VALIDA=0. No further acceptance occurs while held, so a held key produces no auto-repeat.
REQ-008 DEB_RELEASE:
- DEB_CYCLES consecutive low samples SHALL return the FSM to IDLE.
- Any high sample returns the FSM to HELD.
REQ-009 MODO SHALL be sampled at acceptance. A MODO value differing from the previous acceptance SHALL clear the amount buffer and CUENTA_DIG first.
REQ-010 PIN mode:
- A digit SHALL drive DIGITO and pulse DIGITO_STB.
- ENTER and BORRAR SHALL produce no output.
REQ-011 Amount mode, digit key:
- If CUENTA_DIG<MAX_DIG: acc=acc*10+digit and CUENTA_DIG increments.
- Otherwise ERROR_TECLA pulses and acc is unchanged.
REQ-012 Amount mode, ENTER:
- If CUENTA_DIG>0: MONTO=acc, MONTO_STB pulses, and acc and CUENTA_DIG clear.
- If CUENTA_DIG=0: ERROR_TECLA pulses instead.
REQ-013 Amount mode, BORRAR SHALL clear acc and CUENTA_DIG with no strobe.
REQ-014 Codes 12-15 SHALL pulse ERROR_TECLA in either mode.
REQ-015 acc SHALL be 32 bits.
- With MAX_DIG<=9 the maximum is 999999999, so no overflow is possible.
- Parameter values above 9 are illegal.
REQ-016 At most one of DIGITO_STB, MONTO_STB and ERROR_TECLA SHALL be high in any cycle.
REQ-017 All outputs SHALL be registered.

Reset
REQ-018 reset low SHALL immediately force:
- FSM to IDLE, counters to 0 and acc to 0;
- DIGITO=0, DIGITO_STB=0, MONTO=0, MONTO_STB=0, CUENTA_DIG=0, ERROR_TECLA=0;
- the remembered MODO to 0.
REQ-019 Reset asserted mid-debounce or mid-entry SHALL discard all partial input. A key still held at deassertion SHALL be debounced afresh from IDLE.

Structure
REQ-020 Package teclado_pkg SHALL hold:
- key code constants: TECLA_ENTER=10, TECLA_BORRAR=11;
- FSM state typedef;
- MODO_PIN and MODO_MONTO constants.
REQ-021 Debouncing SHALL be a sub-module, antirrebote, with these ports:
- clock, reset, TECLA, TECLA_VALIDA (inputs);
- a one-cycle accepted-pulse output plus the latched code.
The decimal accumulator stays in teclado_atm.

Verification
REQ-022 MODO=0, key 7 held 10 cycles then released -> a single DIGITO_STB carrying DIGITO=7, exactly 4 cycles after the first high sample.
REQ-023 MODO=0, TECLA_VALIDA high for only 3 cycles -> no strobe. Code changing 5 to 6 in the second cycle -> no strobe until 6 has been stable for 4 cycles.
REQ-024 MODO=1, keys 1,2,5,0 then ENTER -> CUENTA_DIG counts 1..4, then MONTO=1250 with MONTO_STB one cycle and CUENTA_DIG=0.
REQ-025 MODO=1, ten digit-9 presses then ENTER:
- the 10th press pulses ERROR_TECLA;
- ENTER then gives MONTO=999999999.
REQ-026 MODO=1, ENTER with an empty buffer -> ERROR_TECLA. Key 13 -> ERROR_TECLA. Digits 4,2 then BORRAR then ENTER -> ERROR_TECLA and MONTO unchanged.
REQ-027 Reset pulsed low during DEB_PRESS and after 3 amount digits:
- all outputs 0 immediately;
- the next ENTER pulses ERROR_TECLA.
